// File: rtl/peg_scorer_pkg.sv
// Shared definitions for the peg scorer: feedback codes, peg count, FSM states.
// Also provides the helper that maps (position, exact, colour) to a feedback digit.
// Feedback digits are sorted: exact first, then colour-only, then none.
package peg_scorer_pkg;

  localparam int NUM_PEGS    = 4;
  localparam int DEF_COLOR_W = 3;

  localparam logic [1:0] FB_NONE  = 2'd0;
  localparam logic [1:0] FB_COLOR = 2'd1;
  localparam logic [1:0] FB_EXACT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXACT = 2'd1,
    S_COLOR = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Digit k of the sorted feedback: exact pegs first, then colour-only pegs.
  function automatic logic [1:0] fb_digit(input logic [2:0] k,
                                          input logic [2:0] ex,
                                          input logic [2:0] co);
    logic [3:0] sum;
    sum = {1'b0, ex} + {1'b0, co};
    if (k < ex)                 return FB_EXACT;
    else if ({1'b0, k} < sum)   return FB_COLOR;
    else                        return FB_NONE;
  endfunction

endpackage

// File: rtl/peg_scorer.sv
// Scores a 4-peg guess against a 4-peg code, one comparison per cycle.
// Latency: done pulses 20 edges after the edge that samples start (start edge counts as edge 1, done seen after edge 21).
// Flow: start is ignored while busy; inputs are latched on accept, later changes have no effect.
module peg_scorer
  import peg_scorer_pkg::*;
#(
  parameter int COLOR_W = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] code0,
  input  logic [COLOR_W-1:0] code1,
  input  logic [COLOR_W-1:0] code2,
  input  logic [COLOR_W-1:0] code3,
  input  logic [COLOR_W-1:0] guess0,
  input  logic [COLOR_W-1:0] guess1,
  input  logic [COLOR_W-1:0] guess2,
  input  logic [COLOR_W-1:0] guess3,
  output logic               busy,
  output logic               done,
  output logic [1:0]         fb0,
  output logic [1:0]         fb1,
  output logic [1:0]         fb2,
  output logic [1:0]         fb3,
  output logic               win
);

  state_t                    state;
  logic [3:0]                idx;
  logic [COLOR_W-1:0]        code_q  [NUM_PEGS];
  logic [COLOR_W-1:0]        guess_q [NUM_PEGS];
  logic [NUM_PEGS-1:0]       used_code;
  logic [NUM_PEGS-1:0]       matched_guess;
  logic [2:0]                exact_cnt;
  logic [2:0]                color_cnt;

  logic [2:0]                ex_nx;
  logic [2:0]                co_nx;
  logic [NUM_PEGS-1:0]       used_nx;
  logic [NUM_PEGS-1:0]       match_nx;
  logic [1:0]                pi;
  logic [1:0]                pj;
  logic [1:0]                fb_nx [NUM_PEGS];

  // One comparison step: exact check on position idx[1:0], or colour check on pair (idx[3:2], idx[1:0]).
  always_comb begin
    ex_nx    = exact_cnt;
    co_nx    = color_cnt;
    used_nx  = used_code;
    match_nx = matched_guess;
    pi       = idx[3:2];
    pj       = idx[1:0];
    if (state == S_EXACT) begin
      if (guess_q[pj] == code_q[pj]) begin
        ex_nx        = exact_cnt + 3'd1;
        used_nx[pj]  = 1'b1;
        match_nx[pj] = 1'b1;
      end
    end else if (state == S_COLOR) begin
      if (!matched_guess[pi] && !used_code[pj] && (guess_q[pi] == code_q[pj])) begin
        co_nx        = color_cnt + 3'd1;
        used_nx[pj]  = 1'b1;
        match_nx[pi] = 1'b1;
      end
    end
    for (int k = 0; k < NUM_PEGS; k++) begin
      fb_nx[k] = fb_digit(3'(k), ex_nx, co_nx);
    end
  end

  // Scoring FSM with registered busy/done/feedback outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= 4'd0;
      used_code     <= '0;
      matched_guess <= '0;
      exact_cnt     <= 3'd0;
      color_cnt     <= 3'd0;
      for (int k = 0; k < NUM_PEGS; k++) begin
        code_q[k]  <= '0;
        guess_q[k] <= '0;
      end
      busy <= 1'b0;
      done <= 1'b0;
      fb0  <= FB_NONE;
      fb1  <= FB_NONE;
      fb2  <= FB_NONE;
      fb3  <= FB_NONE;
      win  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            code_q[0]     <= code0;
            code_q[1]     <= code1;
            code_q[2]     <= code2;
            code_q[3]     <= code3;
            guess_q[0]    <= guess0;
            guess_q[1]    <= guess1;
            guess_q[2]    <= guess2;
            guess_q[3]    <= guess3;
            used_code     <= '0;
            matched_guess <= '0;
            exact_cnt     <= 3'd0;
            color_cnt     <= 3'd0;
            idx           <= 4'd0;
            busy          <= 1'b1;
            state         <= S_EXACT;
          end
        end
        S_EXACT: begin
          exact_cnt     <= ex_nx;
          used_code     <= used_nx;
          matched_guess <= match_nx;
          if (idx == 4'd3) begin
            idx   <= 4'd0;
            state <= S_COLOR;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_COLOR: begin
          color_cnt     <= co_nx;
          used_code     <= used_nx;
          matched_guess <= match_nx;
          idx           <= idx + 4'd1;
          if (idx == 4'd15) begin
            fb0   <= fb_nx[0];
            fb1   <= fb_nx[1];
            fb2   <= fb_nx[2];
            fb3   <= fb_nx[3];
            win   <= (ex_nx == 3'd4);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
